inst_fetch: RTL and testbench

Instruction fetch stage of the RISC-V core, directly upstream of the instruction queue. It walks the program counter, pulls each 32-bit instruction from the byte-wide memory controller as four little-endian byte reads, and pushes the assembled instruction and its PC into the queue when the queue is not full. Branch/jump redirects abort the fetch in progress, discarding any in-flight memory byte, and restart at the new PC.

---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/inst_fetch_assembler.sv | 53 +++++
 rtl/inst_fetch.sv | 121 ++++++++++++
 tb/tb_inst_fetch.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: fetch state
// enumeration, instruction geometry and the default reset PC.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PUSH  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_e;

    localparam int          INST_W           = 32;
    localparam int          BYTES_PER_INST   = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Sequential successor of an instruction address (wraps at 2^32).
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'(BYTES_PER_INST);
    endfunction

endpackage

// File: rtl/inst_fetch_assembler.sv
// Byte assembler: collects three little-endian bytes into a side buffer
// and completes the instruction word when the fourth byte arrives.
module inst_assembler
    import inst_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              take,
    input  logic [7:0]        byte_in,
    output logic [1:0]        cnt,
    output logic              done,
    output logic [INST_W-1:0] word
);

    logic [1:0]        cnt_r;
    logic [INST_W-9:0] buf_r;
    logic [INST_W-1:0] word_r;

    // Byte index, partial buffer and completed word; clr drops a partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= 2'd0;
            buf_r  <= '0;
            word_r <= '0;
        end else if (en) begin
            if (clr) begin
                cnt_r <= 2'd0;
            end else if (take) begin
                if (cnt_r == 2'd3) begin
                    word_r <= {byte_in, buf_r};
                    cnt_r  <= 2'd0;
                end else begin
                    case (cnt_r)
                        2'd0:    buf_r[7:0]   <= byte_in;
                        2'd1:    buf_r[15:8]  <= byte_in;
                        default: buf_r[23:16] <= byte_in;
                    endcase
                    cnt_r <= cnt_r + 2'd1;
                end
            end
        end
    end

    // Completion flag and port views of the registered state.
    always_comb begin
        done = take & (cnt_r == 2'd3);
        cnt  = cnt_r;
        word = word_r;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: walks the PC, reads each instruction as four
// byte requests, pushes completed words into the instruction queue and
// handles branch redirects, including draining a byte still owed by memory.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        jump_i,
    input  logic [31:0] jump_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_valid_i,
    input  logic [7:0]  mem_data_i,
    input  logic        full_i,
    output logic        we_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    fetch_state_e st_r;
    logic [31:0]  pc_r;
    logic         pend_r;
    logic         we_r;
    logic [31:0]  inst_r;
    logic [31:0]  pc_out_r;

    logic [1:0]   cnt_s;
    logic         done_s;
    logic [31:0]  word_s;
    logic         req_s;
    logic         grant_s;
    logic         redirect_s;
    logic         owed_s;
    logic         take_s;

    // Handshake decode: request, grant, redirect and whether a byte stays owed.
    always_comb begin
        req_s      = (st_r == FETCH) & ~pend_r;
        grant_s    = req_s & mem_gnt_i;
        redirect_s = rdy & jump_i & (st_r != IDLE);
        owed_s     = (pend_r & ~mem_valid_i) | grant_s;
        take_s     = rdy & ~redirect_s & (st_r == FETCH) & pend_r & mem_valid_i;
        mem_req_o  = req_s;
        mem_addr_o = pc_r + {30'd0, cnt_s};
        we_o       = we_r;
        inst_o     = inst_r;
        pc_o       = pc_out_r;
    end

    inst_assembler u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (rdy),
        .clr     (redirect_s),
        .take    (take_s),
        .byte_in (mem_data_i),
        .cnt     (cnt_s),
        .done    (done_s),
        .word    (word_s)
    );

    // Fetch FSM, PC, outstanding-byte flag and registered queue write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_r     <= IDLE;
            pc_r     <= RESET_PC;
            pend_r   <= 1'b0;
            we_r     <= 1'b0;
            inst_r   <= 32'd0;
            pc_out_r <= 32'd0;
        end else if (rdy) begin
            we_r <= 1'b0;
            if (redirect_s) begin
                // A byte still owed must be drained before refetching.
                pc_r   <= jump_pc_i;
                pend_r <= owed_s;
                st_r   <= owed_s ? FLUSH : FETCH;
            end else begin
                case (st_r)
                    IDLE: begin
                        st_r <= FETCH;
                    end
                    FETCH: begin
                        if (grant_s) begin
                            pend_r <= 1'b1;
                        end else if (pend_r && mem_valid_i) begin
                            pend_r <= 1'b0;
                            if (done_s) begin
                                st_r <= PUSH;
                            end
                        end
                    end
                    PUSH: begin
                        if (!full_i) begin
                            we_r     <= 1'b1;
                            inst_r   <= word_s;
                            pc_out_r <= pc_r;
                            pc_r     <= next_pc(pc_r);
                            st_r     <= FETCH;
                        end
                    end
                    FLUSH: begin
                        if (mem_valid_i) begin
                            pend_r <= 1'b0;
                            st_r   <= FETCH;
                        end
                    end
                    default: begin
                        st_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by a
// randomized phase, all checked against a transaction-level model of the
// fetch stream (expected PC, bytes collected, word waiting, stale byte).
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        jump_i;
    logic [31:0] jump_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_valid_i;
    logic [7:0]  mem_data_i;
    logic        full_i;
    logic        we_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .jump_i      (jump_i),
        .jump_pc_i   (jump_pc_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_valid_i (mem_valid_i),
        .mem_data_i  (mem_data_i),
        .full_i      (full_i),
        .we_o        (we_o),
        .inst_o      (inst_o),
        .pc_o        (pc_o)
    );

    logic [7:0] mem [0:1023];

    int vectors = 0;
    int fails   = 0;

    // Reference model state
    bit          started, stale, word_ready, outstanding, fast;
    logic [31:0] exp_pc;
    int          nbytes;
    int          lat;
    logic [7:0]  odata;
    logic        last_we;
    logic [31:0] last_pc, last_inst;

    // Values applied during the cycle being processed
    logic        c_rdy, c_jump, c_full, c_req, c_gnt, c_valid;
    logic [31:0] c_jpc, c_addr;

    bit          found;
    logic [31:0] hold_pc, hold_inst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] b;
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < 4; k++) begin
            b = a + 32'(k);
            r[8*k +: 8] = mem[b[9:0]];
        end
        return r;
    endfunction

    task automatic reset_model();
        started     = 1'b0;
        stale       = 1'b0;
        word_ready  = 1'b0;
        outstanding = 1'b0;
        exp_pc      = 32'h0;
        nbytes      = 0;
        lat         = 0;
        last_we     = 1'b0;
        last_pc     = 32'd0;
        last_inst   = 32'd0;
    endtask

    // One clock cycle: check request, drive memory, advance, update model, check outputs.
    task automatic tick();
        logic        exp_req;
        logic        wr_exp;
        logic        owed;
        logic [31:0] wr_pc;
        exp_req = started && !stale && !outstanding && !word_ready;
        chk("mem_req", mem_req_o, exp_req);
        if (exp_req) chk("mem_addr", mem_addr_o, exp_pc + 32'(nbytes));

        mem_gnt_i   = 1'b0;
        mem_valid_i = 1'b0;
        mem_data_i  = 8'($urandom);
        if (rdy) begin
            if (outstanding) begin
                if (lat <= 1) begin
                    mem_valid_i = 1'b1;
                    mem_data_i  = odata;
                end
            end else if (mem_req_o) begin
                mem_gnt_i = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
            end
        end
        c_rdy = rdy; c_jump = jump_i; c_jpc = jump_pc_i; c_full = full_i;
        c_req = mem_req_o; c_addr = mem_addr_o; c_gnt = mem_gnt_i; c_valid = mem_valid_i;

        @(posedge clk);
        @(negedge clk);

        wr_exp = 1'b0;
        wr_pc  = 32'd0;
        if (c_rdy) begin
            owed = (outstanding && !c_valid) || (c_req && c_gnt);
            if (outstanding) begin
                if (c_valid) outstanding = 1'b0;
                else lat--;
            end
            if (c_req && c_gnt) begin
                outstanding = 1'b1;
                odata       = mem[c_addr[9:0]];
                lat         = fast ? 1 : int'($urandom_range(1, 3));
            end
            if (!started) begin
                started = 1'b1;
            end else if (c_jump) begin
                exp_pc     = c_jpc;
                nbytes     = 0;
                word_ready = 1'b0;
                stale      = owed;
            end else if (word_ready) begin
                if (!c_full) begin
                    wr_exp     = 1'b1;
                    wr_pc      = exp_pc;
                    exp_pc     = exp_pc + 32'd4;
                    nbytes     = 0;
                    word_ready = 1'b0;
                end
            end else if (c_valid) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    nbytes++;
                    if (nbytes == 4) word_ready = 1'b1;
                end
            end
            chk("we_o", we_o, wr_exp);
            if (wr_exp) begin
                chk("pc_o", pc_o, wr_pc);
                chk("inst_o", inst_o, ref_word(wr_pc));
            end else begin
                chk("pc_o_keep", pc_o, last_pc);
                chk("inst_o_keep", inst_o, last_inst);
            end
        end else begin
            chk("we_o_hold", we_o, last_we);
            chk("pc_o_hold", pc_o, last_pc);
            chk("inst_o_hold", inst_o, last_inst);
        end
        last_we   = we_o;
        last_pc   = pc_o;
        last_inst = inst_o;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b0; jump_i = 1'b0; jump_pc_i = 32'd0; full_i = 1'b0;
        mem_gnt_i = 1'b0; mem_valid_i = 1'b0; mem_data_i = 8'd0; fast = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;
        reset_model();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_we", we_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_req", mem_req_o, 32'd0);
        rst_n = 1'b1;
        rdy   = 1'b1;

        // Linear fetch of the word at 0
        repeat (9) tick();
        chk("lin_we_early", we_o, 32'd0);
        tick();
        chk("lin_we", we_o, 32'd1);
        chk("lin_inst", inst_o, 32'h0050_0093);
        chk("lin_pc", pc_o, 32'h0);
        chk("lin_next_req", mem_req_o, 32'd1);
        chk("lin_next_addr", mem_addr_o, 32'h4);

        // Backpressure on the word at 0x10
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (word_ready && exp_pc == 32'h10) begin found = 1'b1; break; end
            tick();
        end
        chk("bp_reach", found, 32'd1);
        full_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_we", we_o, 32'd0);
            chk("bp_req", mem_req_o, 32'd0);
        end
        full_i = 1'b0;
        tick();
        chk("bp_we_rel", we_o, 32'd1);
        chk("bp_pc", pc_o, 32'h10);

        // Redirect mid-word: 2 bytes of 0x8 done, grant of the third in flight
        jump_i = 1'b1; jump_pc_i = 32'h8; tick(); jump_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (exp_pc == 32'h8 && nbytes == 2 && mem_req_o) begin found = 1'b1; break; end
            tick();
        end
        chk("rd_reach", found, 32'd1);
        jump_i = 1'b1; jump_pc_i = 32'h100; tick(); jump_i = 1'b0;
        chk("rd_flush_req", mem_req_o, 32'd0);
        tick();
        chk("rd_req", mem_req_o, 32'd1);
        chk("rd_addr", mem_addr_o, 32'h100);
        chk("rd_we", we_o, 32'd0);

        // Redirect coinciding with the final byte valid
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (nbytes == 3 && outstanding) begin found = 1'b1; break; end
            tick();
        end
        chk("fv_reach", found, 32'd1);
        jump_i = 1'b1; jump_pc_i = 32'h200; tick(); jump_i = 1'b0;
        chk("fv_req", mem_req_o, 32'd1);
        chk("fv_addr", mem_addr_o, 32'h200);
        chk("fv_we", we_o, 32'd0);
        tick();
        chk("fv_we_next", we_o, 32'd0);

        // rdy low for 3 cycles while we_o is high
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (we_o) begin found = 1'b1; break; end
            tick();
        end
        chk("hold_reach", found, 32'd1);
        hold_pc = pc_o; hold_inst = inst_o;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_we", we_o, 32'd1);
            chk("hold_pc", pc_o, hold_pc);
            chk("hold_inst", inst_o, hold_inst);
        end
        rdy = 1'b1;
        tick();
        chk("hold_we_clr", we_o, 32'd0);
        chk("hold_next_addr", mem_addr_o, hold_pc + 32'd4);

        // Randomized traffic
        fast = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rdy       = ($urandom_range(0, 9) != 0);
            full_i    = ($urandom_range(0, 3) == 0);
            jump_i    = ($urandom_range(0, 29) == 0);
            jump_pc_i = 32'($urandom_range(0, 255)) << 2;
            tick();
        end
        rdy = 1'b1; full_i = 1'b0; jump_i = 1'b0;

        // Asynchronous reset during FETCH with two bytes collected
        fast = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (started && nbytes == 2 && !stale && !word_ready) begin found = 1'b1; break; end
            tick();
        end
        chk("ar_reach", found, 32'd1);
        #2;
        rst_n = 1'b0; mem_gnt_i = 1'b0; mem_valid_i = 1'b0;
        #1;
        chk("ar_we", we_o, 32'd0);
        chk("ar_inst", inst_o, 32'd0);
        chk("ar_pc", pc_o, 32'd0);
        chk("ar_req", mem_req_o, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ar_req_hold", mem_req_o, 32'd0);
        end
        reset_model();
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req_o) begin found = 1'b1; break; end
            tick();
        end
        chk("ar_req_after", found, 32'd1);
        chk("ar_addr", mem_addr_o, 32'h0);
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
